// File: rtl/pulse_coincidence_counter.sv
// Two-channel pulse singles/coincidence counter over a gated acquisition window.
// Optional PCC_OVERFLOW_EN adds a sticky overflow flag for counter saturation.
module pulse_coincidence_counter #(
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 4,
  parameter int GATE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_a,
  input  logic              pulse_b,
  input  logic [WIN_W-1:0]  window,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
`ifdef PCC_OVERFLOW_EN
  output logic              overflow,
`endif
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_ab
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [WIN_W-1:0]  WIN_ONE  = 1;
  localparam logic [GATE_W-1:0] GATE_ONE = 1;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_ab_q, cnt_ab_d;
  logic [WIN_W-1:0]  arm_a_q, arm_a_d, arm_b_q, arm_b_d, win_q, win_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic              coinc;
`ifdef PCC_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  assign coinc = (pulse_a && pulse_b) || (pulse_b && arm_a_q != '0) ||
                 (pulse_a && arm_b_q != '0);

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    cnt_ab_d = cnt_ab_q;
    arm_a_d  = arm_a_q;
    arm_b_d  = arm_b_q;
    win_d    = win_q;
    gate_d   = gate_q;
`ifdef PCC_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COUNT;
          busy_d   = 1'b1;
          cnt_a_d  = '0;
          cnt_b_d  = '0;
          cnt_ab_d = '0;
          arm_a_d  = '0;
          arm_b_d  = '0;
          win_d    = window;
          gate_d   = (gate_len == '0) ? GATE_ONE : gate_len;
`ifdef PCC_OVERFLOW_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      COUNT: begin
        if (pulse_a && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + CNT_ONE;
        if (pulse_b && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNT_ONE;
        // A coincidence consumes both arms; a lone pulse (re)starts its own window.
        if (coinc) begin
          if (cnt_ab_q != CNT_MAX) cnt_ab_d = cnt_ab_q + CNT_ONE;
          arm_a_d = '0;
          arm_b_d = '0;
        end else begin
          arm_a_d = pulse_a ? win_q : ((arm_a_q != '0) ? arm_a_q - WIN_ONE : '0);
          arm_b_d = pulse_b ? win_q : ((arm_b_q != '0) ? arm_b_q - WIN_ONE : '0);
        end
`ifdef PCC_OVERFLOW_EN
        if ((pulse_a && cnt_a_q == CNT_MAX) || (pulse_b && cnt_b_q == CNT_MAX) ||
            (coinc && cnt_ab_q == CNT_MAX))
          ovf_d = 1'b1;
`endif
        gate_d = gate_q - GATE_ONE;
        if (gate_q == GATE_ONE) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      cnt_ab_q <= '0;
      arm_a_q  <= '0;
      arm_b_q  <= '0;
      win_q    <= '0;
      gate_q   <= '0;
`ifdef PCC_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      cnt_ab_q <= cnt_ab_d;
      arm_a_q  <= arm_a_d;
      arm_b_q  <= arm_b_d;
      win_q    <= win_d;
      gate_q   <= gate_d;
`ifdef PCC_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign cnt_a        = cnt_a_q;
  assign cnt_b        = cnt_b_q;
  assign cnt_ab       = cnt_ab_q;
`ifdef PCC_OVERFLOW_EN
  assign overflow     = ovf_q;
`endif

endmodule

// File: tb/tb_pulse_coincidence_counter.sv
// Directed bench for pulse_coincidence_counter: a 32-bit and a 4-bit instance share stimulus.
module tb_pulse_coincidence_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pulse_a = 1'b0, pulse_b = 1'b0, start = 1'b0, result_ready = 1'b0;
  logic [3:0]  window = '0;
  logic [31:0] gate_len = '0;
  logic        busy, result_valid, s_busy, s_valid;
  logic [31:0] cnt_a, cnt_b, cnt_ab;
  logic [3:0]  s_cnt_a, s_cnt_b, s_cnt_ab;
`ifdef PCC_OVERFLOW_EN
  logic        overflow, s_overflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_coincidence_counter dut (
    .clk(clk), .rst(rst), .pulse_a(pulse_a), .pulse_b(pulse_b), .window(window),
    .gate_len(gate_len), .start(start), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready),
`ifdef PCC_OVERFLOW_EN
    .overflow(overflow),
`endif
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_ab(cnt_ab));

  pulse_coincidence_counter #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .pulse_a(pulse_a), .pulse_b(pulse_b), .window(window),
    .gate_len(gate_len), .start(start), .busy(s_busy), .result_valid(s_valid),
    .result_ready(result_ready),
`ifdef PCC_OVERFLOW_EN
    .overflow(s_overflow),
`endif
    .cnt_a(s_cnt_a), .cnt_b(s_cnt_b), .cnt_ab(s_cnt_ab));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an acquisition; mask bit i drives the pulses of COUNT cycle i+1.
  task automatic acquire(input int g, input int w, input logic [63:0] am,
                         input logic [63:0] bm, input logic pre);
    int n;
    n = (g == 0) ? 1 : g;
    gate_len = g;
    window   = w[3:0];
    start    = 1'b1;
    pulse_a  = pre;
    pulse_b  = pre;
    tick();
    start    = 1'b0;
    gate_len = 32'd3;
    window   = 4'd15;
    for (int i = 0; i < n; i++) begin
      pulse_a = am[i];
      pulse_b = bm[i];
      if (i == n - 1) begin
        check("valid_low_last_count", result_valid, 1'b0);
        check("busy_in_count", busy, 1'b1);
      end
      tick();
    end
    pulse_a = 1'b0;
    pulse_b = 1'b0;
    check("valid_after_gate", result_valid, 1'b1);
    check("busy_in_hold", busy, 1'b1);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("valid_after_accept", result_valid, 1'b0);
    check("busy_after_accept", busy, 1'b0);
  endtask

  task automatic expect_counts(input string tag, input int a, input int b, input int ab);
    check({tag, "_cnt_a"}, cnt_a, a);
    check({tag, "_cnt_b"}, cnt_b, b);
    check({tag, "_cnt_ab"}, cnt_ab, ab);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_valid", result_valid, 1'b0);
    expect_counts("reset", 0, 0, 0);
    rst = 1'b0;
    tick();

    // 1: singles only, W=0, adjacent A->B must not coincide
    acquire(10, 0, 64'h49, 64'h102, 1'b0);
    expect_counts("t1", 3, 2, 0);
    accept();
    check("t1_keep_in_idle", cnt_a, 32'd3);

    // 2: W=3, k=3 counts, second B after clearing does not
    acquire(12, 3, 64'h2, 64'h210, 1'b0);
    expect_counts("t2a", 1, 2, 1);
    accept();
    acquire(12, 3, 64'h2, 64'h20, 1'b0);
    expect_counts("t2b", 1, 1, 0);
    accept();

    // re-trigger restarts the window
    acquire(8, 2, 64'h5, 64'h10, 1'b0);
    expect_counts("retrig", 2, 1, 1);
    accept();

    // 3: same-cycle A&B; pulses before/at start and after gate ignored
    pulse_a = 1'b1; pulse_b = 1'b1;
    tick();
    acquire(6, 0, 64'h4, 64'h4, 1'b1);
    pulse_a = 1'b1; pulse_b = 1'b1;
    tick();
    pulse_a = 1'b0; pulse_b = 1'b0;
    expect_counts("t3", 1, 1, 1);
    accept();

    // gate_len=0 behaves as a single counted cycle
    acquire(0, 0, 64'h1, 64'h0, 1'b0);
    expect_counts("gate0", 1, 0, 0);
    accept();

    // 4: stall in HOLD with start and pulses toggling
    acquire(5, 0, 64'h1, 64'h2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      start   = (i % 5 == 2);
      pulse_a = 1'b1;
      pulse_b = (i % 2 == 0);
      tick();
      check("hold_valid", result_valid, 1'b1);
      check("hold_cnt_a", cnt_a, 32'd1);
      check("hold_cnt_b", cnt_b, 32'd1);
    end
    start = 1'b0; pulse_a = 1'b0; pulse_b = 1'b0;
    accept();
    tick();
    check("idle_stays", busy, 1'b0);

    // 5: async reset mid-count
    gate_len = 32'd20; window = 4'd0; start = 1'b1;
    tick();
    start = 1'b0; pulse_a = 1'b1;
    tick(); tick(); tick();
    pulse_a = 1'b0;
    check("t5_live_cnt_a", cnt_a, 32'd3);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_valid", result_valid, 1'b0);
    expect_counts("t5_rst", 0, 0, 0);
    rst = 1'b0;
    tick();
    check("t5_no_result", result_valid, 1'b0);
    acquire(4, 0, 64'h1, 64'h0, 1'b0);
    expect_counts("t5_fresh", 1, 0, 0);
    accept();

    // 6: saturation on the 4-bit instance
    acquire(25, 0, 64'hFFFFF, 64'h0, 1'b0);
    check("t6_big_cnt_a", cnt_a, 32'd20);
    check("t6_small_cnt_a", s_cnt_a, 4'd15);
    check("t6_small_cnt_ab", s_cnt_ab, 4'd0);
`ifdef PCC_OVERFLOW_EN
    check("t6_small_ovf", s_overflow, 1'b1);
    check("t6_big_ovf", overflow, 1'b0);
`endif
    accept();
`ifdef PCC_OVERFLOW_EN
    check("t6_ovf_held_idle", s_overflow, 1'b1);
`endif
    gate_len = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_restart_cnt", s_cnt_a, 4'd0);
`ifdef PCC_OVERFLOW_EN
    check("t6_ovf_cleared", s_overflow, 1'b0);
`endif
    tick(); tick();
    accept();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
